// File: rtl/wsp_sequencer.sv
`timescale 1ns/1ps
// IEEE 1500 Wrapper Serial Port sequencer: runs one CAPTURE/SHIFT/UPDATE access per host command.
// Optional build macro WSP_NOCAP_EN adds cmd_nocap, which lets a command skip the CaptureWR cycle.
module wsp_sequencer #(
    parameter int DR_MAX = 32,
    parameter int LEN_W  = 6
) (
    input  logic              WRCK,
    input  logic              WRSTN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_is_ir,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DR_MAX-1:0] cmd_data,
`ifdef WSP_NOCAP_EN
    input  logic              cmd_nocap,
`endif
    output logic              rsp_valid,
    output logic [DR_MAX-1:0] rsp_data,
    output logic              select_wir,
    output logic              capture_wr,
    output logic              shift_wr,
    output logic              update_wr,
    output logic              wsi,
    input  logic              wso,
    output logic              busy
);

    localparam int               IDX_W   = $clog2(DR_MAX);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DR_MAX);

    typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, UPDATE} state_t;

    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_acc;
    logic [DR_MAX-1:0] sh;
    logic              skip_cap;

    assign len_acc = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;

`ifdef WSP_NOCAP_EN
    assign skip_cap = cmd_nocap;
`else
    assign skip_cap = 1'b0;
`endif

    // Held low while reset is asserted so the host never sees a ready it cannot use.
    assign cmd_ready = WRSTN && (state == IDLE);
    assign busy      = (state != IDLE);

    // WSP controls are registered and set on the edge entering their state, so they
    // depend only on flops; wsi is preloaded with the next bit to leave the buffer.
    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            state      <= IDLE;
            len_q      <= '0;
            cnt        <= '0;
            sh         <= '0;
            rsp_data   <= '0;
            rsp_valid  <= 1'b0;
            select_wir <= 1'b0;
            capture_wr <= 1'b0;
            shift_wr   <= 1'b0;
            update_wr  <= 1'b0;
            wsi        <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        select_wir <= cmd_is_ir;
                        len_q      <= len_acc;
                        sh         <= cmd_data;
                        cnt        <= '0;
                        rsp_data   <= '0;
                        if (!skip_cap) begin
                            state      <= CAPTURE;
                            capture_wr <= 1'b1;
                        end else if (len_acc != '0) begin
                            state    <= SHIFT;
                            shift_wr <= 1'b1;
                            wsi      <= cmd_data[0];
                        end else begin
                            state     <= UPDATE;
                            update_wr <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    capture_wr <= 1'b0;
                    if (len_q != '0) begin
                        state    <= SHIFT;
                        shift_wr <= 1'b1;
                        wsi      <= sh[0];
                    end else begin
                        state     <= UPDATE;
                        update_wr <= 1'b1;
                    end
                end
                SHIFT: begin
                    sh                     <= sh >> 1;
                    rsp_data[cnt[IDX_W-1:0]] <= wso;
                    cnt                    <= cnt + 1'b1;
                    if (cnt == len_q - 1'b1) begin
                        state     <= UPDATE;
                        shift_wr  <= 1'b0;
                        wsi       <= 1'b0;
                        update_wr <= 1'b1;
                    end else begin
                        wsi <= sh[1];
                    end
                end
                UPDATE: begin
                    state      <= IDLE;
                    update_wr  <= 1'b0;
                    select_wir <= 1'b0;
                    rsp_valid  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wsp_sequencer.sv
`timescale 1ns/1ps
// Directed bench for wsp_sequencer: a behavioural WDR/WIR chain on wsi/wso and a scoreboard
// queue of expected transactions popped whenever rsp_valid is seen.
module tb_wsp_sequencer;

    localparam int DR_MAX = 32;
    localparam int LEN_W  = 6;

    logic              WRCK = 1'b0;
    logic              WRSTN = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_is_ir = 1'b0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [DR_MAX-1:0] cmd_data = '0;
`ifdef WSP_NOCAP_EN
    logic              cmd_nocap = 1'b0;
`endif
    logic              rsp_valid;
    logic [DR_MAX-1:0] rsp_data;
    logic              select_wir;
    logic              capture_wr;
    logic              shift_wr;
    logic              update_wr;
    logic              wsi;
    logic              wso;
    logic              busy;

    int checks = 0;
    int errors = 0;

    wsp_sequencer #(.DR_MAX(DR_MAX), .LEN_W(LEN_W)) dut (
        .WRCK       (WRCK),
        .WRSTN      (WRSTN),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_is_ir  (cmd_is_ir),
        .cmd_len    (cmd_len),
        .cmd_data   (cmd_data),
`ifdef WSP_NOCAP_EN
        .cmd_nocap  (cmd_nocap),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .select_wir (select_wir),
        .capture_wr (capture_wr),
        .shift_wr   (shift_wr),
        .update_wr  (update_wr),
        .wsi        (wsi),
        .wso        (wso),
        .busy       (busy)
    );

    always #5 WRCK = ~WRCK;

    typedef struct {
        logic [31:0] rsp;
        logic [31:0] wsi_bits;
        logic [31:0] preload;
        logic [31:0] chain_final;
        logic        is_ir;
        int          len;
        int          busy_len;
        int          caps;
        int          chain_n;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [31:0] mask(input int n);
        if (n >= 32) return '1;
        return (32'd1 << n) - 32'd1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Chain model: loads its capture value on CaptureWR (or a direct preload), shifts LSB-out on ShiftWR.
    logic [31:0] chain = '0;
    int          chain_n = 32;
    logic        force_load = 1'b0;
    logic [31:0] force_val = '0;
    int          force_n = 32;

    assign wso = chain[0];

    always @(posedge WRCK) begin
        if (force_load) begin
            chain   <= force_val;
            chain_n <= force_n;
        end else if (capture_wr && exp_q.size() > 0) begin
            chain   <= exp_q[0].preload;
            chain_n <= exp_q[0].chain_n;
        end else if (shift_wr) begin
            chain <= (chain >> 1) | ({31'b0, wsi} << (chain_n - 1));
        end
    end

    // Per-cycle protocol monitor and scoreboard consumer.
    int          busy_cnt = 0;
    int          shift_cnt = 0;
    int          cap_cnt = 0;
    int          upd_cnt = 0;
    logic [31:0] wsi_seen = '0;
    logic        sel_txn = 1'b0;

    always @(negedge WRCK) begin
        exp_t e;
        if (!WRSTN) begin
            busy_cnt  = 0;
            shift_cnt = 0;
            cap_cnt   = 0;
            upd_cnt   = 0;
            wsi_seen  = '0;
        end else begin
            checkOutput("ctrl_onehot0", 32'($countones({capture_wr, shift_wr, update_wr}) <= 1), 32'd1);
            if (!shift_wr) checkOutput("wsi_outside_shift", 32'(wsi), 32'd0);
            if (busy) begin
                if (busy_cnt == 0) begin
                    sel_txn = select_wir;
                    if (exp_q.size() > 0) checkOutput("select_wir_value", 32'(select_wir), 32'(exp_q[0].is_ir));
                end else begin
                    checkOutput("select_wir_stable", 32'(select_wir), 32'(sel_txn));
                end
                busy_cnt++;
                if (capture_wr) cap_cnt++;
                if (update_wr) upd_cnt++;
                if (shift_wr) begin
                    if (shift_cnt < 32) wsi_seen[shift_cnt] = wsi;
                    shift_cnt++;
                end
                if (update_wr && exp_q.size() > 0)
                    checkOutput("chain_at_update", chain & mask(exp_q[0].chain_n), exp_q[0].chain_final);
            end else begin
                checkOutput("select_wir_idle", 32'(select_wir), 32'd0);
            end
            if (rsp_valid) begin
                checkOutput("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("rsp_data", rsp_data, e.rsp);
                    checkOutput("busy_cycles", 32'(busy_cnt), 32'(e.busy_len));
                    checkOutput("shift_cycles", 32'(shift_cnt), 32'(e.len));
                    checkOutput("capture_cycles", 32'(cap_cnt), 32'(e.caps));
                    checkOutput("update_cycles", 32'(upd_cnt), 32'd1);
                    checkOutput("wsi_stream", wsi_seen, e.wsi_bits);
                end
                busy_cnt  = 0;
                shift_cnt = 0;
                cap_cnt   = 0;
                upd_cnt   = 0;
                wsi_seen  = '0;
            end
        end
    end

    // Builds the expected record, drives one command and returns at the falling edge after it is taken.
    task automatic applyStimulus(input logic is_ir, input int len_cmd, input logic [31:0] data,
                                 input logic [31:0] preload, input int n, input logic nocap);
        exp_t        e;
        logic [31:0] c;
        int          leff;
        int          waited;
        leff = (len_cmd > DR_MAX) ? DR_MAX : len_cmd;
        c = preload & mask(n);
        e.rsp = '0;
        for (int i = 0; i < leff; i++) begin
            e.rsp[i] = c[0];
            c = ((c >> 1) | ({31'b0, data[i]} << (n - 1))) & mask(n);
        end
        e.chain_final = c;
        e.preload     = preload;
        e.wsi_bits    = data & mask(leff);
        e.is_ir       = is_ir;
        e.len         = leff;
        e.busy_len    = leff + (nocap ? 1 : 2);
        e.caps        = nocap ? 0 : 1;
        e.chain_n     = n;
        if (nocap) begin
            force_val  = preload;
            force_n    = n;
            force_load = 1'b1;
            @(negedge WRCK);
            force_load = 1'b0;
        end
        exp_q.push_back(e);
        cmd_is_ir = is_ir;
        cmd_len   = LEN_W'(len_cmd);
        cmd_data  = data;
`ifdef WSP_NOCAP_EN
        cmd_nocap = nocap;
`endif
        cmd_valid = 1'b1;
        waited = 0;
        while (!cmd_ready && waited < 200) begin
            @(negedge WRCK);
            waited++;
        end
        checkOutput("accept_timeout", 32'(waited < 200), 32'd1);
        if (waited > 0) checkOutput("b2b_accept_in_rsp_cycle", 32'(rsp_valid), 32'd1);
        @(negedge WRCK);
        cmd_valid = 1'b0;
        checkOutput("first_cycle_after_accept", 32'(nocap ? (shift_wr | update_wr) : capture_wr), 32'd1);
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || busy) && n < 500) begin
            @(negedge WRCK);
            n++;
        end
        checkOutput("drain_timeout", 32'(n < 500), 32'd1);
        @(negedge WRCK);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rnd_data;
        logic [31:0] rnd_pre;
        repeat (3) @(negedge WRCK);
        checkOutput("reset_cmd_ready_low", 32'(cmd_ready), 32'd0);
        WRSTN = 1'b1;
        @(negedge WRCK);
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_ctrls", 32'({select_wir, capture_wr, shift_wr, update_wr, wsi}), 32'd0);
        checkOutput("reset_rsp", rsp_data, 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("[TB] WIR load len=3");
        applyStimulus(1'b1, 3, 32'b101, 32'b110, 3, 1'b0);
        waitIdle();

        $display("[TB] WDR loopback len=32");
        applyStimulus(1'b0, 32, 32'h12345678, 32'hDEADBEEF, 32, 1'b0);
        waitIdle();

        $display("[TB] len=0 and len=40 boundaries");
        applyStimulus(1'b0, 0, 32'hFFFFFFFF, 32'hCAFEF00D, 32, 1'b0);
        waitIdle();
        applyStimulus(1'b0, 40, 32'h0BADC0DE, 32'h13579BDF, 32, 1'b0);
        waitIdle();
        checkOutput("rsp_data_holds", rsp_data, 32'h13579BDF);

        $display("[TB] back-to-back commands");
        applyStimulus(1'b1, 5, 32'h00000016, 32'h00000009, 5, 1'b0);
        applyStimulus(1'b0, 16, 32'h0000A5C3, 32'h87654321, 32, 1'b0);
        waitIdle();

        $display("[TB] reset during shift");
        applyStimulus(1'b0, 8, 32'h000000A5, 32'h0F0F0F0F, 32, 1'b0);
        @(negedge WRCK);
        @(negedge WRCK);
        @(posedge WRCK);
        #1;
        checkOutput("in_third_shift", 32'(shift_wr), 32'd1);
        #1;
        WRSTN = 1'b0;
        #1;
        checkOutput("abort_ctrls", 32'({select_wir, capture_wr, shift_wr, update_wr, wsi}), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_rsp_data", rsp_data, 32'd0);
        checkOutput("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge WRCK);
        WRSTN = 1'b1;
        repeat (3) begin
            @(negedge WRCK);
            checkOutput("post_abort_no_update", 32'(update_wr), 32'd0);
            checkOutput("post_abort_no_rsp", 32'(rsp_valid), 32'd0);
            checkOutput("post_abort_ready", 32'(cmd_ready), 32'd1);
        end

        $display("[TB] random WDR after reset");
        rnd_data = $urandom;
        rnd_pre  = $urandom;
        applyStimulus(1'b0, 12, rnd_data, rnd_pre, 32, 1'b0);
        waitIdle();

`ifdef WSP_NOCAP_EN
        $display("[TB] no-capture commands");
        applyStimulus(1'b1, 4, 32'b1001, 32'b0110, 4, 1'b1);
        waitIdle();
        applyStimulus(1'b1, 0, 32'b1111, 32'b0101, 4, 1'b1);
        waitIdle();
        applyStimulus(1'b1, 4, 32'b0011, 32'b1010, 4, 1'b0);
        waitIdle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wsp_sequencer.md
Name: wsp_sequencer

Overview:
- Wrapper Serial Port (WSP) sequencer for the IEEE 1500 wrapper.
- Takes one command at a time from a host-side valid/ready interface and drives the WIR/WDR serial controls: select_wir, capture_wr, shift_wr, update_wr, wsi.
- Collects wso bits during shift and returns them as a parallel response word.
- Sits between the test host and the WIRBuilding/WDR chain; all logic is on the WRCK domain.

Parameters:
- DR_MAX, 32, maximum shift length in bits; width of cmd_data and rsp_data.
- LEN_W, 6, width of cmd_len. Must satisfy 2^LEN_W > DR_MAX.

Ports:
- WRCK  in  1  wrapper clock; single clock for the whole block.
- WRSTN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_is_ir  in  1  1 = WIR access (select_wir high), 0 = WDR access.
- cmd_len  in  LEN_W  number of bits to shift.
- cmd_data  in  DR_MAX  shift-in data, LSB shifted first.
- rsp_valid  out  1  one-cycle pulse: transaction complete.
- rsp_data  out  DR_MAX  captured wso bits, first bit in bit 0; bits at and above len are 0.
- select_wir  out  1  WSP SelectWIR.
- capture_wr  out  1  WSP CaptureWR.
- shift_wr  out  1  WSP ShiftWR.
- update_wr  out  1  WSP UpdateWR.
- wsi  out  1  serial data to the chain.
- wso  in  1  serial data from the chain.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (WRSTN=0, asynchronous):
  - state = IDLE.
  - All WSP outputs, rsp_valid, busy and wsi = 0; rsp_data = 0; shift buffer and counter cleared; cmd_ready = 1 once WRSTN=1.
  - A reset mid-transaction aborts it immediately: no rsp_valid, and update_wr is not issued.
- Accept: on a WRCK rising edge with cmd_valid & cmd_ready.
  - Latch cmd_is_ir, len = min(cmd_len, DR_MAX), and cmd_data into buffer sh.
  - Clear the bit counter.
- States: IDLE -> CAPTURE -> SHIFT -> UPDATE -> IDLE.
  - IDLE: cmd_ready=1 and all WSP controls 0. On accept, go to CAPTURE.
  - CAPTURE: exactly 1 cycle with capture_wr=1. Next state is SHIFT if len>0, else UPDATE.
  - SHIFT: exactly len cycles with shift_wr=1 and wsi = sh[0].
    - At each rising edge: sh <= sh>>1, and rsp bit [cnt] <= wso; cnt <= cnt+1.
    - Leave when cnt == len-1.
  - UPDATE: exactly 1 cycle with update_wr=1. Next state is IDLE, and rsp_valid=1 in the first IDLE cycle.
- select_wir:
  - Equals the latched cmd_is_ir from the CAPTURE cycle through the UPDATE cycle.
  - 0 in IDLE.
  - Constant for the whole transaction.
- At most one of capture_wr, shift_wr, update_wr is high in any cycle.
- WSP controls are decoded from registered state only; there is no combinational path from cmd_* to WSP outputs.
- wsi = 0 outside SHIFT.
- Latency:
  - Accept edge to first capture_wr cycle: 1 cycle.
  - Transaction length: len+2 cycles.
  - rsp_valid: in the cycle after UPDATE.
- Back-to-back commands: a command presented during the rsp_valid cycle is accepted at that edge (cmd_ready=1 in IDLE). Minimum gap between update_wr and the next capture_wr is 1 IDLE cycle.
- Length handling:
  - cmd_len=0: CAPTURE then UPDATE, no shift, rsp_data = 0.
  - cmd_len > DR_MAX: clamped to DR_MAX.
- rsp_data holds its value until the next accept, where it is cleared.
- cmd_valid while busy is ignored; cmd_ready=0, and the host must hold the command.

Optional Feature:
- Macro WSP_NOCAP_EN.
- Defined:
  - Adds input port cmd_nocap (1 bit), latched on accept.
  - If it is 1, the CAPTURE state is skipped: IDLE goes directly to SHIFT, or to UPDATE when len=0.
  - Transaction length is then len+1 cycles. This is used for WIR loads where the capture value is irrelevant.
- Undefined:
  - Port absent; CAPTURE is always executed.

Test Plan:
- Reset mid-shift: WDR command, len=8; assert WRSTN=0 on the 3rd shift cycle.
  - Required: all outputs 0 asynchronously, no update_wr, no rsp_valid; cmd_ready=1 after release.
- WIR load: cmd_is_ir=1, len=3, data=3'b101.
  - Required: select_wir=1 for 5 cycles; capture 1 cycle; shift 3 cycles with wsi=1,0,1; update 1 cycle.
  - Required: rsp_valid 1 cycle later; rsp_data = wso bits sampled, with wso looped to a 3-bit model returning its prior value.
- WDR loopback: model the chain as a 32-bit shift register preloaded with 0xDEADBEEF; command len=32, data=0x12345678.
  - Required: rsp_data = 0xDEADBEEF; model holds 0x12345678 at update; 34 busy cycles.
- Boundaries: len=0 -> capture then update, rsp_data=0. len=40 -> exactly 32 shift cycles.
- Back-to-back and protocol check:
  - Second command held valid during busy is accepted in the rsp_valid cycle.
  - Assert one-hot-or-zero on the three WSP controls every cycle.
  - Assert select_wir is stable across each transaction.
- WSP_NOCAP_EN: with cmd_nocap=1 and len=4, capture_wr is never asserted and the transaction is 5 cycles. With cmd_nocap=0, behaviour is identical to the macro-undefined build.
